// File: rtl/mux_scan_sequencer_if.sv
// Load handshake and mux-drive bundle for mux_scan_sequencer.
// The master side offers words; the slave side (the sequencer) drives the mux.
interface mux_scan_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             load_dir;
  logic [WIDTH-1:0] data_out;
  logic [SEL_W-1:0] sel;
  logic             bit_out;
  logic             bit_valid;
  logic             last;
  logic             busy;

  modport master (
    output load_valid, load_data, load_dir,
    input  load_ready, data_out, sel, bit_out, bit_valid, last, busy
  );

  modport slave (
    input  load_valid, load_data, load_dir,
    output load_ready, data_out, sel, bit_out, bit_valid, last, busy
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Captures a word and steps the 8:1 mux select across it, echoing the selected bit.
// Optional macro PARITY_EN appends an even-parity bit period after the data bits.
module mux_scan_sequencer #(
  parameter int WIDTH    = 8,
  parameter int SEL_W    = 3,
  parameter int STEP_DIV = 1
) (
  input logic                 clk,
  input logic                 reset,
  mux_scan_sequencer_if.slave bus
);

  localparam int                DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [SEL_W-1:0]  SEL_MAX  = SEL_W'(WIDTH - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SCAN, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SCAN} state_t;
`endif

  state_t           r_state, w_stateNext;
  logic [WIDTH-1:0] r_data, w_dataNext;
  logic [SEL_W-1:0] r_sel, w_selNext;
  logic             r_dir, w_dirNext;
  logic [DIV_W-1:0] r_div, w_divNext;
  logic             r_bitValid, r_last, r_busy;
  logic             w_lastNext, w_activeNext, w_loadReady;
  logic [SEL_W-1:0] w_selEnd, w_selEndNext;

  assign w_loadReady  = (r_state == IDLE) && !reset;
  assign w_selEnd     = r_dir ? '0 : SEL_MAX;
  assign w_selEndNext = w_dirNext ? '0 : SEL_MAX;

  always_comb begin
    w_stateNext = r_state;
    w_dataNext  = r_data;
    w_selNext   = r_sel;
    w_dirNext   = r_dir;
    w_divNext   = r_div;
    unique case (r_state)
      IDLE: begin
        if (bus.load_valid && w_loadReady) begin
          w_dataNext  = bus.load_data;
          w_dirNext   = bus.load_dir;
          w_selNext   = bus.load_dir ? SEL_MAX : '0;
          w_divNext   = '0;
          w_stateNext = SCAN;
        end
      end
      SCAN: begin
        if (r_div == DIV_LAST) begin
          w_divNext = '0;
          if (r_sel == w_selEnd) begin
`ifdef PARITY_EN
            w_stateNext = PAR;
`else
            w_stateNext = IDLE;
`endif
          end else begin
            w_selNext = r_dir ? (r_sel - SEL_W'(1)) : (r_sel + SEL_W'(1));
          end
        end else begin
          w_divNext = r_div + DIV_W'(1);
        end
      end
`ifdef PARITY_EN
      PAR: begin
        if (r_div == DIV_LAST) begin
          w_divNext   = '0;
          w_stateNext = IDLE;
        end else begin
          w_divNext = r_div + DIV_W'(1);
        end
      end
`endif
      default: w_stateNext = IDLE;
    endcase

    w_activeNext = (w_stateNext != IDLE);
    // last is registered, so it is decided from where the next cycle will be
`ifdef PARITY_EN
    w_lastNext = (w_stateNext == PAR);
`else
    w_lastNext = (w_stateNext == SCAN) && (w_selNext == w_selEndNext);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_sel      <= '0;
      r_dir      <= 1'b0;
      r_div      <= '0;
      r_bitValid <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_data     <= w_dataNext;
      r_sel      <= w_selNext;
      r_dir      <= w_dirNext;
      r_div      <= w_divNext;
      r_bitValid <= w_activeNext;
      r_last     <= w_lastNext;
      r_busy     <= w_activeNext;
    end
  end

  assign bus.load_ready = w_loadReady;
  assign bus.data_out   = r_data;
  assign bus.sel        = r_sel;
  assign bus.bit_valid  = r_bitValid;
  assign bus.last       = r_last;
  assign bus.busy       = r_busy;
`ifdef PARITY_EN
  assign bus.bit_out = r_bitValid && ((r_state == PAR) ? (^r_data) : r_data[r_sel]);
`else
  assign bus.bit_out = r_bitValid && r_data[r_sel];
`endif

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
Upstream driver for the 8:1 multiplexer stage. It accepts a parallel word through a valid/ready handshake and holds it on data_out, which feeds the mux data input. It then steps the select code across all inputs, one step every STEP_DIV cycles, ascending or descending. It also reproduces the selected bit locally as bit_out, so downstream logic and benches can check mux output against it.

Parameters:
WIDTH, 8, data word width; must equal 2**SEL_W
SEL_W, 3, select code width driven to the mux
STEP_DIV, 1, clock cycles each select value is held; legal range >= 1

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
load_valid  input  1  load_data/load_dir offered this cycle
load_ready  output  1  block can accept a word this cycle
load_data  input  WIDTH  word to scan
load_dir  input  1  0 = ascending select (0..WIDTH-1), 1 = descending
data_out  output  WIDTH  captured word, drives mux data input
sel  output  SEL_W  current select code, drives mux select
bit_out  output  1  data_out[sel] while bit_valid, else 0
bit_valid  output  1  sel/bit_out meaningful this cycle
last  output  1  final bit of the word is being presented
busy  output  1  scan in progress (state != IDLE)

Behaviour:
- Reset (reset=1 at a rising edge) puts the block in IDLE and clears its outputs: sel=0, data_out=0, bit_out=0, bit_valid=0, last=0, busy=0, divider=0. load_ready is 0 while reset is high.
- States are IDLE and SCAN, plus PAR when PARITY_EN is defined. load_ready = (state==IDLE) && !reset.
- IDLE: handshake fires at an edge with load_valid && load_ready. At that edge the block captures data_out<=load_data and latches dir<=load_dir. It sets sel<=(dir ? WIDTH-1 : 0) and divider<=0, then moves to SCAN.
- Latency: handshake at edge N puts the first bit on bit_out in the cycle after edge N.
- SCAN: bit_valid=1 and busy=1. The divider counts 0..STEP_DIV-1.
  - At divider==STEP_DIV-1, if sel is not at its end value, sel steps by +1 (asc) or -1 (desc) and the divider clears.
  - The end value is WIDTH-1 for asc and 0 for desc. Reaching it at divider==STEP_DIV-1 leaves SCAN: to IDLE without the feature, to PAR with it.
- sel never wraps within a word. A scan is exactly WIDTH*STEP_DIV cycles.
- last=1 for all STEP_DIV cycles of the final bit presented.
- After a word the block sits in IDLE for at least one cycle, so max throughput is one word per WIDTH*STEP_DIV+1 cycles.
- Returning to IDLE: bit_valid=0, busy=0, bit_out=0. data_out and sel keep their final values until the next load or reset.
- load_valid, load_data and load_dir are ignored while busy. Changes to them mid-scan have no effect.
- Reset mid-scan: at the next edge all outputs clear as above. The word is discarded and no last pulse is emitted.
- reset and load_valid at the same edge: reset wins and the word is not accepted.
- All outputs except load_ready and bit_out are registered. bit_out is combinational from data_out, sel and bit_valid.

Optional Feature:
Macro PARITY_EN.
- Defined: after the final data bit the block enters PAR for STEP_DIV cycles.
  - In PAR: bit_valid=1, sel holds its end value, bit_out = even parity (XOR of all data_out bits), last=1 throughout PAR.
  - last is not asserted on the final data bit.
  - Word period becomes (WIDTH+1)*STEP_DIV+1 cycles.
- Undefined: no PAR state. last marks the final data bit, and behaviour is exactly as in Behaviour.

Test Plan:
- STEP_DIV=1, dir=0, load 8'b11101010 -> sel 0..7 on consecutive cycles; bit_out 0,1,0,1,0,1,1,1; last only with sel=7; load_ready=1 on the following cycle.
- dir=1, load 8'b00100011 -> sel 7..0; bit_out 0,0,1,0,0,0,1,1; last with sel=0; data_out=8'b00100011 held afterwards.
- STEP_DIV=3, load 8'b00000000 -> each sel value held 3 cycles; 24 cycles with bit_valid=1 and bit_out=0; last for the 3 cycles of sel=7.
- load_valid held high with load_data toggling every cycle -> exactly one word accepted per 9 cycles (STEP_DIV=1); mid-scan data changes never appear on data_out.
- Reset asserted while sel=4 -> next cycle sel=0, data_out=0, bit_valid=0, busy=0, no last; load_ready=1 once reset drops.
- PARITY_EN defined, load 8'b11101010, dir=0 -> 8 data bits as in the first scenario with last=0, then a 9th bit_out=1 with last=1 and sel=7; then IDLE.
